// File: rtl/timer_bank.sv
// Bank of independent prescaled up/down timers with sticky done/overrun flags.
// Commands address one channel at a time; done_ack clears flags even while frozen.
module timer_bank #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 16,
  parameter  int PRE_W    = 8,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [SEL_W-1:0]    sel,
  input  logic                set,
  input  logic                stop,
  input  logic                direction,
  input  logic                auto_reload,
  input  logic [WIDTH-1:0]    count,
  input  logic [PRE_W-1:0]    prescale,
  input  logic [CHANNELS-1:0] done_ack,
  output logic [CHANNELS-1:0] done,
  output logic [CHANNELS-1:0] overrun,
  output logic [CHANNELS-1:0] running,
  output logic                irq
);

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [WIDTH-1:0]    rld_q [CHANNELS];
  logic [WIDTH-1:0]    rld_d [CHANNELS];
  logic [PRE_W-1:0]    pre_q [CHANNELS];
  logic [PRE_W-1:0]    pre_d [CHANNELS];
  logic [PRE_W-1:0]    pval_q [CHANNELS];
  logic [PRE_W-1:0]    pval_d [CHANNELS];
  logic [CHANNELS-1:0] dir_q, dir_d;
  logic [CHANNELS-1:0] arl_q, arl_d;
  logic [CHANNELS-1:0] run_q, run_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] ovr_q, ovr_d;

  logic [CHANNELS-1:0] set_hit, stop_hit, tick, step, at_term;

  // Command decode; an out-of-range sel matches no channel.
  always_comb begin
    set_hit  = '0;
    stop_hit = '0;
    tick     = '0;
    step     = '0;
    at_term  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      set_hit[i]  = enable && set && (int'(sel) == i);
      stop_hit[i] = enable && stop && !set && (int'(sel) == i);
      tick[i]     = enable && run_q[i] && !set_hit[i] && !stop_hit[i];
      step[i]     = tick[i] && (pre_q[i] == '0);
      at_term[i]  = (cnt_q[i] == {WIDTH{dir_q[i]}});
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    rld_d  = rld_q;
    pre_d  = pre_q;
    pval_d = pval_q;
    dir_d  = dir_q;
    arl_d  = arl_q;
    run_d  = run_q;
    done_d = done_q;
    ovr_d  = ovr_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (set_hit[i]) begin
        cnt_d[i]  = count;
        rld_d[i]  = count;
        pre_d[i]  = prescale;
        pval_d[i] = prescale;
        dir_d[i]  = direction;
        arl_d[i]  = auto_reload;
        run_d[i]  = 1'b1;
        done_d[i] = 1'b0;
        ovr_d[i]  = 1'b0;
      end else begin
        if (done_ack[i]) begin
          done_d[i] = 1'b0;
          ovr_d[i]  = 1'b0;
        end
        if (stop_hit[i]) begin
          run_d[i] = 1'b0;
        end else if (tick[i] && !step[i]) begin
          pre_d[i] = pre_q[i] - PRE_W'(1);
        end else if (step[i]) begin
          pre_d[i] = pval_q[i];
          if (at_term[i]) begin
            // Terminal beats a same-cycle ack; overrun reflects the flag before this edge.
            done_d[i] = 1'b1;
            ovr_d[i]  = ovr_q[i] | done_q[i];
            if (arl_q[i]) cnt_d[i] = rld_q[i];
            else          run_d[i] = 1'b0;
          end else if (dir_q[i]) begin
            cnt_d[i] = cnt_q[i] + WIDTH'(1);
          end else begin
            cnt_d[i] = cnt_q[i] - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        rld_q[i]  <= '0;
        pre_q[i]  <= '0;
        pval_q[i] <= '0;
      end
      dir_q  <= '0;
      arl_q  <= '0;
      run_q  <= '0;
      done_q <= '0;
      ovr_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rld_q  <= rld_d;
      pre_q  <= pre_d;
      pval_q <= pval_d;
      dir_q  <= dir_d;
      arl_q  <= arl_d;
      run_q  <= run_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
    end
  end

  assign done    = done_q;
  assign overrun = ovr_q;
  assign running = run_q;
  assign irq     = |done_q;

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent timer channels, 1..16.
REQ-002 SHALL have parameter WIDTH, default 16: counter width in bits, 2..32.
REQ-003 SHALL have parameter PRE_W, default 8: prescaler width in bits, 1..16.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1 bit: global run gate; low freezes every counter and prescaler.
REQ-007 SHALL have port sel, input, $clog2(CHANNELS) bits (min 1): channel addressed by set/stop.
REQ-008 SHALL have port set, input, 1 bit: load and start channel sel.
REQ-009 SHALL have port stop, input, 1 bit: halt channel sel without clearing its counter.
REQ-010 SHALL have port direction, input, 1 bit: 1 = count up, 0 = count down, sampled on set.
REQ-011 SHALL have port auto_reload, input, 1 bit: 1 = reload on terminal, 0 = one-shot, sampled on set.
REQ-012 SHALL have port count, input, WIDTH bits: start and reload value, sampled on set.
REQ-013 SHALL have port prescale, input, PRE_W bits: step every prescale+1 enabled cycles, sampled on set.
REQ-014 SHALL have port done_ack, input, CHANNELS bits: per-channel clear of done and overrun.
REQ-015 SHALL have port done, output, CHANNELS bits: sticky terminal flag per channel.
REQ-016 SHALL have port overrun, output, CHANNELS bits: terminal occurred while done already set.
REQ-017 SHALL have port running, output, CHANNELS bits: channel run state.
REQ-018 SHALL have port irq, output, 1 bit: combinational OR of done.

Function
REQ-019 Each channel SHALL hold: counter[WIDTH], reload[WIDTH], pre_cnt[PRE_W], pre_val[PRE_W], dir, auto, run, done, overrun.
REQ-020 Commands (set, stop) SHALL be accepted only while enable=1; set has priority over stop; sel >= CHANNELS is ignored.
REQ-021 On set: counter<=count, reload<=count, pre_cnt<=prescale, pre_val<=prescale, dir, auto captured, run<=1, done<=0, overrun<=0, visible next edge; a set on a running channel restarts it.
REQ-022 On stop: run<=0; counter, done, overrun hold.
REQ-023 Tick: enable=1, run=1, no set/stop on this channel; pre_cnt==0 -> step and pre_cnt<=pre_val, else pre_cnt decrements.
REQ-024 Terminal value: 0 when dir=0, all-ones when dir=1.
REQ-025 Step with counter != terminal: counter +1 (dir=1) or -1 (dir=0), modulo 2^WIDTH.
REQ-026 Step with counter == terminal: done<=1; overrun<=1 if done already 1; counter<=reload and run holds if auto=1, else counter holds and run<=0.
REQ-027 Down-count latency: done rises at the edge ending the (count+1)*(prescale+1)-th tick cycle after the set cycle; up-count uses (2^WIDTH-count) in place of count+1.
REQ-028 done_ack[i] SHALL clear done[i] and overrun[i] next edge; a same-cycle terminal or set on channel i wins over the ack.
REQ-029 enable=0 SHALL freeze all channel state except done/overrun clears by done_ack, which act regardless of enable.
REQ-030 Channels SHALL be fully independent; simultaneous terminals on several channels each set their own done.

Reset
REQ-031 rst_n=0 SHALL immediately clear counter, reload, pre_cnt, pre_val, dir, auto, run, done, overrun in all channels; outputs done, overrun, running, irq = 0.
REQ-032 Reset asserted mid-count SHALL abort every channel; after release, no channel runs until a new set.

Verification
REQ-033 CHANNELS=4, WIDTH=16: set ch0 count=3 prescale=0 down one-shot -> done[0]=1 and irq=1 at 4th tick edge; running[0]=0; counter[0] holds 0.
REQ-034 Set ch1 count=2 prescale=2 down auto -> done[1] rises after 9 ticks; never acked -> overrun[1]=1 after 18 ticks; done_ack[1] -> both clear next edge.
REQ-035 Set ch2 count=16'hFFFE up one-shot -> done[2] after 2 ticks; drop enable for 5 cycles mid-count -> done delayed by exactly 5 cycles.
REQ-036 Terminal on ch0 and done_ack[0] in same cycle -> done[0] stays 1; stop on ch3 mid-count -> running[3]=0, counter holds, done[3]=0.
REQ-037 All channels running, rst_n pulsed low between edges -> all outputs 0 immediately, no done after release until new set.
